// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory request/response and decode handshake bundle around the fetch stage
//   imem_req_valid/addr/ready  request channel to instruction memory
//   imem_rsp_valid/data/err    in-order response channel from instruction memory
//   inst_valid/inst/inst_pc/inst_fault/inst_ready  fetched instruction to decode
//   master = fetch stage view, slave = memory/decode view
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic        inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32E fetch stage, issues in-order imem requests for pc_i and queues words for decode
//   clk, rst_n   clock, asynchronous active-low reset
//   pc_i         current PC
//   pc_ready_o   fetch of pc_i issued this cycle, PC may advance
//   flush_i      redirect: drop the queue and every in-flight response
//   bus          instruction_fetch_if.master: imem request/response and decode handshake
module instruction_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                pc_i,
    output logic                       pc_ready_o,
    input  logic                       flush_i,
    instruction_fetch_if.master        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    logic [31:0]   q_data  [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [1:0]    q_fault [DEPTH];
    logic [31:0]   t_pc    [DEPTH];
    logic [AW-1:0] q_wr, q_rd, t_wr, t_rd;
    logic [CW-1:0] occ, outstanding, discard;
    logic [CW:0]   load;
    logic          aligned, pop, credit, req_fire, mis_fire, rsp_take, push;
    logic [31:0]   push_data, push_pc;
    logic [1:0]    push_fault;

    always_comb begin
        aligned             = pc_i[1:0] == 2'b00;
        bus.inst_valid      = (occ != '0) & ~flush_i;
        bus.inst            = q_data[q_rd];
        bus.inst_pc         = q_pc[q_rd];
        bus.inst_fault      = q_fault[q_rd];
        pop                 = bus.inst_valid & bus.inst_ready;
        // Counting the slot freed by this cycle's decode pop sustains one fetch per cycle at DEPTH=2.
        load                = {1'b0, occ} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
        credit              = load < LIMIT;
        bus.imem_req_valid  = rst_n & credit & ~flush_i & aligned;
        bus.imem_req_addr   = pc_i;
        req_fire            = bus.imem_req_valid & bus.imem_req_ready;
        // Misaligned PCs bypass memory but must wait until older fetches drain to keep order.
        mis_fire            = rst_n & credit & ~aligned & (outstanding == '0) & ~flush_i;
        pc_ready_o          = req_fire | mis_fire;
        // A response with nothing outstanding is stale (e.g. issued before reset) and ignored.
        rsp_take            = bus.imem_rsp_valid & (outstanding != '0);
        push                = mis_fire | (rsp_take & (discard == '0) & ~flush_i);
        push_data           = mis_fire ? NOP_INST : bus.imem_rsp_data;
        push_pc             = mis_fire ? pc_i : t_pc[t_rd];
        push_fault          = mis_fire ? 2'b10 : (bus.imem_rsp_err ? 2'b01 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (req_fire) t_pc[t_wr] <= pc_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i]  <= '0;
                q_pc[i]    <= '0;
                q_fault[i] <= '0;
            end
            q_wr        <= '0;
            q_rd        <= '0;
            t_wr        <= '0;
            t_rd        <= '0;
            occ         <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (req_fire) t_wr <= t_wr + 1'b1;
            if (rsp_take) t_rd <= t_rd + 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            // Discarded responses still retire tracking entries so PCs stay paired with data.
            discard     <= flush_i ? outstanding - CW'(rsp_take)
                                   : discard - CW'(rsp_take && discard != '0);
            if (flush_i) begin
                q_wr <= '0;
                q_rd <= '0;
                occ  <= '0;
            end else begin
                if (push) begin
                    q_data[q_wr]  <= push_data;
                    q_pc[q_wr]    <= push_pc;
                    q_fault[q_wr] <= push_fault;
                    q_wr          <= q_wr + 1'b1;
                end
                if (pop) q_rd <= q_rd + 1'b1;
                occ <= occ + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
